// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: packs RGB565 pixels eight to a 128-bit word, queues the words and writes fixed-length DDR bursts
module ddr_frame_writer #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int LVL_W      = 6
) (
  input  logic             i_cap_clk,
  input  logic             i_cap_rst_n,
  input  logic             i_pix_vsync,
  input  logic             i_pix_de,
  input  logic [4:0]       i_pix_r,
  input  logic [5:0]       i_pix_g,
  input  logic [4:0]       i_pix_b,
  input  logic             i_ddr_wr_rdy,
  output logic             o_ddr_addr_set,
  output logic             o_ddr_wr_cmd,
  output logic             o_ddr_wren,
  output logic [127:0]     o_ddr_wr_data,
  output logic [LVL_W-1:0] o_fifo_level,
  output logic             o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  typedef enum logic [1:0] {IDLE, CMD, BURST} state_t;
  state_t           r_state, w_next;
  logic             r_vsync_d, r_addr_set, r_overflow;
  logic [2:0]       r_pack_cnt;
  logic [127:0]     r_pack;
  logic [127:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LVL_W-1:0] r_level;
  logic [BW-1:0]    r_beat_cnt;
  logic             w_fstart, w_push_req, w_push, w_pop, w_full, w_last;
  logic [127:0]     w_word;
  assign w_fstart       = r_vsync_d & ~i_pix_vsync;
  assign w_word         = r_pack | ({i_pix_r, i_pix_g, i_pix_b, 112'd0} >> {r_pack_cnt, 4'd0});
  assign w_push_req     = ~w_fstart & (i_pix_de ? r_pack_cnt == 3'd7 : r_pack_cnt != 3'd0);
  assign w_full         = r_level == LVL_W'(FIFO_DEPTH);
  assign w_pop          = o_ddr_wren & i_ddr_wr_rdy;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push         = w_push_req & (~w_full | w_pop);
  assign w_last         = r_beat_cnt == BW'(BURST_LEN - 1);
  assign o_ddr_wr_cmd   = r_state == CMD;
  assign o_ddr_wren     = r_state == BURST;
  assign o_ddr_wr_data  = r_level != '0 ? r_mem[r_rp] : '0;
  assign o_fifo_level   = r_level;
  assign o_overflow     = r_overflow;
  assign o_ddr_addr_set = r_addr_set;
  always_ff @(posedge i_cap_clk) begin
    r_vsync_d  <= i_cap_rst_n & i_pix_vsync;
    r_addr_set <= i_cap_rst_n & w_fstart;
  end
  always_ff @(posedge i_cap_clk)
    if (w_push) r_mem[r_wp] <= i_pix_de ? w_word : r_pack;
  always_ff @(posedge i_cap_clk) begin
    if (!i_cap_rst_n || w_fstart) begin
      r_pack_cnt <= '0;
      r_pack     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pack_cnt <= i_pix_de ? r_pack_cnt + 3'd1 : 3'd0;
      r_pack     <= (i_pix_de && r_pack_cnt != 3'd7) ? w_word : '0;
      r_wp       <= r_wp + AW'(w_push);
      r_rp       <= r_rp + AW'(w_pop);
      r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_push_req && !w_push) r_overflow <= 1'b1;
    end
  end
  always_ff @(posedge i_cap_clk) begin
    if (!i_cap_rst_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_beat_cnt <= r_state == CMD ? '0 : r_beat_cnt + BW'(w_pop);
    end
  end
  // CMD sits between IDLE and BURST, which also guarantees the idle cycle after a burst
  always_comb begin
    w_next = r_state;
    if (w_fstart) w_next = IDLE;
    else if (r_state == IDLE) w_next = r_level >= LVL_W'(BURST_LEN) ? CMD : IDLE;
    else if (r_state == CMD) w_next = BURST;
    else if (r_state == BURST) w_next = (w_pop && w_last) ? IDLE : BURST;
    else w_next = IDLE;
  end
endmodule
